// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types and width constants for the cache-to-memory
//                arbiter (FSM states, requester identity, bus widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned BE_W   = LINE_W / 8;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    // Which cache owns (or last owned) the memory port
    typedef enum logic [0:0] {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_mem_arbiter_grant_sel.sv
`default_nettype none
// ============================================================================
//  Module      : arb_grant_sel
//  Description : Combinational winner select between the I-cache and D-cache
//                requests. With CACHE_ARB_RR_EN defined, ties go to the
//                requester that did not win last time; otherwise the D-cache
//                always wins ties.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_grant_sel
    import cache_pkg::*;
(
    input  logic       icache_req,
    input  logic       dcache_req,
`ifdef CACHE_ARB_RR_EN
    input  requester_t last_grant,
`endif
    output logic       grant_valid,
    output requester_t grant
);

    // Pick a winner whenever at least one cache is requesting
    always_comb begin
        grant_valid = icache_req | dcache_req;
        grant       = REQ_D;
        if (icache_req && !dcache_req) begin
            grant = REQ_I;
        end else if (icache_req && dcache_req) begin
`ifdef CACHE_ARB_RR_EN
            grant = (last_grant == REQ_D) ? REQ_I : REQ_D;
`else
            grant = REQ_D;
`endif
        end
    end

endmodule : arb_grant_sel
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_arbiter
//  Description : Shares one cacheline adaptor port between the I-cache
//                (read-only) and D-cache (read/write). Grants one whole line
//                transaction at a time, latches the winning request and routes
//                the completion pulse back to the winner only.
//                Optional feature macro: CACHE_ARB_RR_EN (round-robin ties).
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W = cache_pkg::ADDR_W,
    parameter int unsigned LINE_W = cache_pkg::LINE_W,
    parameter int unsigned BE_W   = cache_pkg::BE_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_mem_address,
    input  logic              i_mem_read,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,

    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [LINE_W-1:0] d_mem_wdata,
    input  logic [BE_W-1:0]   d_mem_byte_enable,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,

    output logic [ADDR_W-1:0] ca_mem_address,
    output logic              ca_mem_read,
    output logic              ca_mem_write,
    output logic [LINE_W-1:0] ca_mem_wdata,
    output logic [BE_W-1:0]   ca_mem_byte_enable,
    input  logic [LINE_W-1:0] ca_mem_rdata,
    input  logic              ca_mem_resp
);
    import cache_pkg::*;

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              w_load;
    logic              w_clear;
    logic              w_grant_valid;
    requester_t        w_grant;
    logic              w_dcache_req;

    logic [ADDR_W-1:0] r_addr;
    logic              r_read;
    logic              r_write;
    logic [LINE_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;

    assign w_dcache_req = d_mem_read | d_mem_write;

`ifdef CACHE_ARB_RR_EN
    requester_t        r_last_grant;

    // Remember who won most recently so the other side wins the next tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= REQ_D;
        end else if (w_load) begin
            r_last_grant <= w_grant;
        end
    end
`endif

    arb_grant_sel u_grant_sel (
        .icache_req  (i_mem_read),
        .dcache_req  (w_dcache_req),
`ifdef CACHE_ARB_RR_EN
        .last_grant  (r_last_grant),
`endif
        .grant_valid (w_grant_valid),
        .grant       (w_grant)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic plus load/clear strobes for the request latch
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_load       = 1'b1;
                    w_next_state = (w_grant == REQ_I) ? BUSY_I : BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (ca_mem_resp) begin
                    w_clear      = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // Requesters get this cycle to drop their request
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Latch the winner's request; only strobes clear on completion so that
    // address and data stay put until the adaptor is done with them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_load) begin
            if (w_grant == REQ_I) begin
                r_addr  <= i_mem_address;
                r_read  <= 1'b1;
                r_write <= 1'b0;
                r_wdata <= '0;
                r_be    <= '1;
            end else begin
                // Write takes precedence if the D-cache raises both strobes
                r_addr  <= d_mem_address;
                r_read  <= d_mem_read & ~d_mem_write;
                r_write <= d_mem_write;
                r_wdata <= d_mem_wdata;
                r_be    <= d_mem_byte_enable;
            end
        end else if (w_clear) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
        end
    end

    assign ca_mem_address     = r_addr;
    assign ca_mem_read        = r_read;
    assign ca_mem_write       = r_write;
    assign ca_mem_wdata       = r_wdata;
    assign ca_mem_byte_enable = r_be;

    // Read data is broadcast; only the owner's resp qualifies it
    assign i_mem_rdata = ca_mem_rdata;
    assign d_mem_rdata = ca_mem_rdata;
    assign i_mem_resp  = ca_mem_resp & (r_state == BUSY_I);
    assign d_mem_resp  = ca_mem_resp & (r_state == BUSY_D);

endmodule : cache_mem_arbiter
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_mem_arbiter
//  Description : Self-checking bench for cache_mem_arbiter. Acts as both
//                caches and the cacheline adaptor; expected grant order and
//                downstream fields come from a request-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int BW = 32;

    logic          clk;
    logic          rst;
    logic [AW-1:0] i_mem_address;
    logic          i_mem_read;
    logic [LW-1:0] i_mem_rdata;
    logic          i_mem_resp;
    logic [AW-1:0] d_mem_address;
    logic          d_mem_read;
    logic          d_mem_write;
    logic [LW-1:0] d_mem_wdata;
    logic [BW-1:0] d_mem_byte_enable;
    logic [LW-1:0] d_mem_rdata;
    logic          d_mem_resp;
    logic [AW-1:0] ca_mem_address;
    logic          ca_mem_read;
    logic          ca_mem_write;
    logic [LW-1:0] ca_mem_wdata;
    logic [BW-1:0] ca_mem_byte_enable;
    logic [LW-1:0] ca_mem_rdata;
    logic          ca_mem_resp;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Request intent as issued by the bench-side caches
    logic [AW-1:0] e_i_addr;
    logic [AW-1:0] e_d_addr;
    logic          e_d_rd;
    logic          e_d_wr;
    logic [LW-1:0] e_d_wdata;
    logic [BW-1:0] e_d_be;
`ifdef CACHE_ARB_RR_EN
    bit            exp_last;   // 0 = I won last, 1 = D won last
`endif

    cache_mem_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .i_mem_address      (i_mem_address),
        .i_mem_read         (i_mem_read),
        .i_mem_rdata        (i_mem_rdata),
        .i_mem_resp         (i_mem_resp),
        .d_mem_address      (d_mem_address),
        .d_mem_read         (d_mem_read),
        .d_mem_write        (d_mem_write),
        .d_mem_wdata        (d_mem_wdata),
        .d_mem_byte_enable  (d_mem_byte_enable),
        .d_mem_rdata        (d_mem_rdata),
        .d_mem_resp         (d_mem_resp),
        .ca_mem_address     (ca_mem_address),
        .ca_mem_read        (ca_mem_read),
        .ca_mem_write       (ca_mem_write),
        .ca_mem_wdata       (ca_mem_wdata),
        .ca_mem_byte_enable (ca_mem_byte_enable),
        .ca_mem_rdata       (ca_mem_rdata),
        .ca_mem_resp        (ca_mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Arbitration rule: lone requester wins; ties by round-robin or D-first
    function automatic bit pick_d(input bit ir, input bit dr);
        if (ir && dr) begin
`ifdef CACHE_ARB_RR_EN
            return (exp_last == 1'b0);
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction

    task automatic rand_fields();
        e_i_addr  = $urandom & 32'hFFFF_FFE0;
        e_d_addr  = $urandom & 32'hFFFF_FFE0;
        e_d_wdata = rand_line();
        e_d_be    = $urandom;
    endtask

    task automatic set_reqs(input bit ir, input bit drd, input bit dwr);
        e_d_rd            = drd;
        e_d_wr            = dwr;
        i_mem_read        = ir;
        i_mem_address     = e_i_addr;
        d_mem_read        = drd;
        d_mem_write       = dwr;
        d_mem_address     = e_d_addr;
        d_mem_wdata       = e_d_wdata;
        d_mem_byte_enable = e_d_be;
    endtask

    task automatic drop_req(input bit who_d);
        if (who_d) begin
            d_mem_read    = 1'b0;
            d_mem_write   = 1'b0;
            d_mem_address = $urandom;
            d_mem_wdata   = rand_line();
        end else begin
            i_mem_read    = 1'b0;
            i_mem_address = $urandom;
        end
    endtask

    // Called at a negedge while the arbiter is IDLE with the winner's request
    // visible; returns at the negedge two cycles after the adaptor response.
    task automatic serve(input bit who_d, input int lat, input bit drop_mid,
                         input logic [LW-1:0] rdata, input bit spur_done);
        logic [AW-1:0]  ea;
        logic           er;
        logic           ew;
        logic [LW-1:0]  ewd;
        logic [BW-1:0]  ebe;
        logic [321:0]   obs_f;
        logic [321:0]   exp_f;
        if (who_d) begin
            ea = e_d_addr; er = e_d_rd & ~e_d_wr; ew = e_d_wr; ewd = e_d_wdata; ebe = e_d_be;
        end else begin
            ea = e_i_addr; er = 1'b1; ew = 1'b0; ewd = '0; ebe = '1;
        end
        exp_f = {er, ew, ea, ew ? ewd : {LW{1'b0}}, ebe};
        @(negedge clk);
        obs_f = {ca_mem_read, ca_mem_write, ca_mem_address, ew ? ca_mem_wdata : {LW{1'b0}}, ca_mem_byte_enable};
        check(who_d ? "grant_d_fields" : "grant_i_fields", obs_f, exp_f);
        for (int c = 0; c < lat; c++) begin
            if (drop_mid && c == 1) drop_req(who_d);
            @(negedge clk);
            obs_f = {ca_mem_read, ca_mem_write, ca_mem_address, ew ? ca_mem_wdata : {LW{1'b0}}, ca_mem_byte_enable};
            check("hold_fields", obs_f, exp_f);
            check("no_early_resp", {i_mem_resp, d_mem_resp}, 2'b00);
        end
        ca_mem_rdata = rdata;
        ca_mem_resp  = 1'b1;
        #1;
        check("resp_route", {i_mem_resp, d_mem_resp}, who_d ? 2'b01 : 2'b10);
        check("rdata_bcast", {i_mem_rdata, d_mem_rdata}, {rdata, rdata});
        @(negedge clk);
        ca_mem_resp = spur_done;
        drop_req(who_d);
        #1;
        check("strobe_clear", {ca_mem_read, ca_mem_write}, 2'b00);
        check("done_no_resp", {i_mem_resp, d_mem_resp}, 2'b00);
        @(negedge clk);
        ca_mem_resp = 1'b0;
        check("gap_strobe", {ca_mem_read, ca_mem_write}, 2'b00);
`ifdef CACHE_ARB_RR_EN
        exp_last = who_d;
`endif
    endtask

    initial begin
        bit ir;
        bit drd;
        bit dwr;
        bit wd;
`ifdef CACHE_ARB_RR_EN
        exp_last = 1'b1;
`endif
        rst = 1'b1;
        ca_mem_resp  = 1'b0;
        ca_mem_rdata = '0;

        // Reset with both caches already requesting
        rand_fields();
        set_reqs(1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_strobes", {ca_mem_read, ca_mem_write}, 2'b00);
        check("rst_addr", ca_mem_address, 32'h0);
        check("rst_wdata", ca_mem_wdata, {LW{1'b0}});
        check("rst_be", ca_mem_byte_enable, 32'h0);
        check("rst_resp", {i_mem_resp, d_mem_resp}, 2'b00);
        rst = 1'b0;
        wd = pick_d(1'b1, 1'b1);
        serve(wd, 3, 1'b0, rand_line(), 1'b0);
        serve(!wd, 2, 1'b0, rand_line(), 1'b0);

        // I-cache read of 0x1000, slow adaptor
        e_i_addr = 32'h0000_1000;
        set_reqs(1'b1, 1'b0, 1'b0);
        serve(1'b0, 10, 1'b0, {32{8'hA5}}, 1'b0);

        // D-cache partial write of 0x2000
        e_d_addr  = 32'h0000_2000;
        e_d_wdata = {8{32'h1234_5678}};
        e_d_be    = 32'hFFFF_0000;
        set_reqs(1'b0, 1'b0, 1'b1);
        serve(1'b1, 4, 1'b0, rand_line(), 1'b1);

        // D-cache read and write together: write wins
        e_d_addr = 32'h0000_3000;
        set_reqs(1'b0, 1'b1, 1'b1);
        serve(1'b1, 3, 1'b0, rand_line(), 1'b0);

        // D-cache gives up mid-transaction: still completes
        rand_fields();
        set_reqs(1'b0, 1'b1, 1'b0);
        serve(1'b1, 5, 1'b1, rand_line(), 1'b0);

        // Stray adaptor response while idle
        ca_mem_resp = 1'b1;
        #1;
        check("idle_spurious", {i_mem_resp, d_mem_resp}, 2'b00);
        @(negedge clk);
        ca_mem_resp = 1'b0;
        check("idle_no_grant", {ca_mem_read, ca_mem_write}, 2'b00);

        // Reset in the middle of a D transaction
        rand_fields();
        set_reqs(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_read", {ca_mem_read, ca_mem_write}, 2'b10);
        @(negedge clk);
        rst = 1'b1;
        set_reqs(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_mid_strobes", {ca_mem_read, ca_mem_write}, 2'b00);
        check("rst_mid_addr", ca_mem_address, 32'h0);
        rst = 1'b0;
        ca_mem_resp = 1'b1;
        #1;
        check("rst_mid_no_resp", {i_mem_resp, d_mem_resp}, 2'b00);
        @(negedge clk);
        ca_mem_resp = 1'b0;
`ifdef CACHE_ARB_RR_EN
        exp_last = 1'b1;
`endif

        // Randomised traffic
        for (int t = 0; t < 40; t++) begin
            rand_fields();
            ir  = $urandom_range(0, 1) != 0;
            drd = $urandom_range(0, 1) != 0;
            dwr = $urandom_range(0, 1) != 0;
            if (!ir && !drd && !dwr) ir = 1'b1;
            set_reqs(ir, drd, dwr);
            wd = pick_d(ir, drd | dwr);
            serve(wd, $urandom_range(0, 6), $urandom_range(0, 3) == 0, rand_line(),
                  $urandom_range(0, 1) != 0);
            if (ir && (drd || dwr)) begin
                serve(!wd, $urandom_range(0, 6), 1'b0, rand_line(), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_cache_mem_arbiter
`default_nettype wire

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-requester arbiter that shares the single cacheline adaptor port to physical memory between the instruction cache (read-only) and the data cache (read/write). It sits between the two cache controllers and the cacheline adaptor. It grants one whole cacheline transaction at a time, latches the winning request, and routes the response back to the winner only.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `LINE_W`, 256, cacheline data width.
- `BE_W`, 32, byte-enable width (`LINE_W/8`).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `i_mem_address`  in  ADDR_W  I-cache line address.
- `i_mem_read`  in  1  I-cache read request (level, held until response).
- `i_mem_rdata`  out  LINE_W  read line to I-cache.
- `i_mem_resp`  out  1  I-cache completion pulse.
- `d_mem_address`  in  ADDR_W  D-cache line address.
- `d_mem_read`  in  1  D-cache read request.
- `d_mem_write`  in  1  D-cache write request.
- `d_mem_wdata`  in  LINE_W  D-cache write line.
- `d_mem_byte_enable`  in  BE_W  D-cache byte enables.
- `d_mem_rdata`  out  LINE_W  read line to D-cache.
- `d_mem_resp`  out  1  D-cache completion pulse.
- `ca_mem_address`  out  ADDR_W  to adaptor.
- `ca_mem_read`  out  1  to adaptor.
- `ca_mem_write`  out  1  to adaptor.
- `ca_mem_wdata`  out  LINE_W  to adaptor.
- `ca_mem_byte_enable`  out  BE_W  to adaptor; all-ones for I-cache reads.
- `ca_mem_rdata`  in  LINE_W  from adaptor.
- `ca_mem_resp`  in  1  from adaptor; one-cycle pulse.

## Operation
- States:
  - `IDLE`: samples requests.
  - `BUSY_I`: I-cache transaction outstanding.
  - `BUSY_D`: D-cache transaction outstanding.
  - `DONE`: one-cycle recovery; requests ignored.
- `IDLE`:
  - I request only: go to `BUSY_I`.
  - D request (read or write) only: go to `BUSY_D`.
  - Both requesting: arbitration rule (see Configuration).
  - Neither: stay.
- On grant, latch the winner's address, read/write, wdata and byte enables into registers. Downstream `ca_*` outputs are driven only from these registers.
- `BUSY_x`:
  - Hold latched strobe until `ca_mem_resp`.
  - On `ca_mem_resp`: go to `DONE`, clear strobes.
- `DONE`: go to `IDLE` unconditionally. This gives requesters one cycle to deassert after their response.
- `i_mem_resp = ca_mem_resp & (state==BUSY_I)`.
- `d_mem_resp = ca_mem_resp & (state==BUSY_D)`.
- `i_mem_rdata` and `d_mem_rdata` both equal `ca_mem_rdata` (broadcast). Only the `resp` signal qualifies the data.
- `d_mem_read` and `d_mem_write` both high: write wins; read is ignored.
- Requester deasserting mid-transaction: no abort. The latched request completes and `resp` is still pulsed.
- `ca_mem_resp` in `IDLE` or `DONE`: ignored, no `resp` is forwarded.
- `rst` mid-transaction: state goes to `IDLE`, strobes clear at that edge, and the RR pointer resets. The adaptor is reset by the same `rst`.
- Reset values:
  - state `IDLE`.
  - `ca_mem_read`, `ca_mem_write` = 0.
  - `ca_mem_address`, `ca_mem_wdata`, `ca_mem_byte_enable` = 0.
  - `i_mem_resp`, `d_mem_resp` = 0.
  - `last_grant` = D.

## Timing
- Request high in `IDLE` at cycle 0 → state `BUSY_x` and `ca_mem_read`/`ca_mem_write` high from cycle 1. The 1-cycle grant latency is registered.
- `ca_mem_resp` at cycle N → requester `resp` at cycle N (combinational). Strobes are low from N+1, `DONE` at N+1, `IDLE` at N+2.
- Earliest next grant is sampled at N+2, with strobe at N+3. Minimum gap between downstream transactions is 2 idle strobe cycles.
- Downstream strobes never toggle during a transaction. Address and data are stable from grant until `resp`.

## Configuration
- `CACHE_ARB_RR_EN` defined: round-robin on conflicts.
  - A 1-bit `last_grant` register is updated on every grant.
  - When both caches request in `IDLE`, grant the one not equal to `last_grant`.
  - Reset `last_grant` = D, so the I-cache wins the first tie.
- `CACHE_ARB_RR_EN` undefined: fixed priority, D-cache always wins ties. The `last_grant` register is not instantiated.

## Structure
- Shared package `cache_pkg`:
  - `arb_state_t` enum (`IDLE`, `BUSY_I`, `BUSY_D`, `DONE`).
  - `requester_t` enum (`REQ_I`, `REQ_D`).
  - Width constants `LINE_W`, `ADDR_W`, `BE_W`.
- One sub-module: `arb_grant_sel`, a combinational winner select from the two requests plus `last_grant`. It contains the `CACHE_ARB_RR_EN` branch.
- FSM, latch registers and response routing stay in the top module.

## Test plan
- I read only, addr 0x0000_1000; adaptor `resp` 10 cycles after strobe.
  - `ca_mem_read`=1 from cycle 1, address 0x1000, byte enable all-ones.
  - `i_mem_resp` pulses once with line 0xA5…A5.
  - `d_mem_resp` stays 0.
- D write 0x2000, wdata 0x1234…, BE 0xFFFF_0000.
  - `ca_mem_write`=1, wdata and BE held stable until `resp`.
  - `d_mem_resp` 1 cycle; `IDLE` 2 cycles later.
- I and D request simultaneously at reset release, held across both transactions.
  - RR build: I served first, then D.
  - Non-RR build: D first, then I.
  - Next grant strobe 3 cycles after the first `resp`.
- D asserts read and write together at 0x3000 → only `ca_mem_write`=1.
- D drops request 2 cycles after grant → transaction completes and `d_mem_resp` still pulses. Spurious `ca_mem_resp` in `IDLE` → no `resp` forwarded.
- `rst` asserted while in `BUSY_D` → next cycle state `IDLE`, strobes 0, and no `resp` output for the aborted transaction.
